// File: rtl/dac_sample_sched.sv
// Sample scheduler: FIFO-buffered upstream samples released to the DAC chain once every osr_i+1 cycles.
// Optional DAC_SCHED_RAMP_EN build adds a MUTE state that ramps dac_o to zero on stop.
module dac_sample_sched #(
  parameter int BW    = 16,
  parameter int OSR_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [OSR_W-1:0] osr_i,
  input  logic             s_valid_i,
  input  logic [BW-1:0]    s_data_i,
  output logic             s_ready_o,
  output logic [BW-1:0]    dac_o,
  output logic             strobe_o,
  output logic             underflow_o,
  input  logic             clr_i,
  output logic [1:0]       state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    MUTE  = 2'd3
  } state_t;

  state_t                 state;
  logic [BW-1:0]          mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic [OSR_W-1:0]       cnt;
  logic signed [BW-1:0]   dac_q;
  logic                   strobe_q;
  logic                   underflow_q;

  logic push;
  logic pop;
  logic tick;
  logic stop;
  logic flush;

  assign s_ready_o = (count != CW'(DEPTH)) && rst_i;
  assign push      = s_valid_i && s_ready_o;
  assign tick      = ((state == RUN) || (state == MUTE)) && (cnt >= osr_i);
  assign stop      = (state == RUN) && !en_i;
  // A stop request takes priority over a tick that lands on the same edge.
  assign pop       = (state == RUN) && en_i && tick && (count != '0);

`ifdef DAC_SCHED_RAMP_EN
  localparam logic signed [BW-1:0] RAMP_LIM = BW'(8);

  logic                 near_zero;
  logic signed [BW-1:0] ramp_next;

  assign near_zero = (dac_q < RAMP_LIM) && (dac_q > -RAMP_LIM);
  assign ramp_next = dac_q - (dac_q >>> 3);
  assign flush     = (state == MUTE) && tick && near_zero;
`else
  assign flush     = stop;
`endif

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= s_data_i;
    end
  end

  // Flushing on the way back to IDLE discards any push landing on that same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      dac_q       <= '0;
      strobe_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (clr_i) begin
        underflow_q <= 1'b0;
      end

      if ((state == RUN) || (state == MUTE)) begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      // Underflow set below is the later assignment, so it beats a same-cycle clear.
      case (state)
        IDLE: begin
          dac_q <= '0;
          if (en_i) begin
            state <= PRIME;
          end
        end

        PRIME: begin
          if (!en_i) begin
            state <= IDLE;
          end else if (count >= CW'(DEPTH / 2)) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (stop) begin
`ifdef DAC_SCHED_RAMP_EN
            state <= MUTE;
`else
            state <= IDLE;
            dac_q <= '0;
            cnt   <= '0;
`endif
          end else if (tick) begin
            strobe_q <= 1'b1;
            if (count != '0) begin
              dac_q <= mem[rd_ptr];
            end else begin
              underflow_q <= 1'b1;
            end
          end
        end

        MUTE: begin
`ifdef DAC_SCHED_RAMP_EN
          if (tick) begin
            strobe_q <= 1'b1;
            if (near_zero) begin
              dac_q <= '0;
              state <= IDLE;
            end else begin
              dac_q <= ramp_next;
            end
          end
`else
          state <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign dac_o       = dac_q;
  assign strobe_o    = strobe_q;
  assign underflow_o = underflow_q;
  assign state_o     = state;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Directed self-checking bench for dac_sample_sched (default build; ramp stop covered when DAC_SCHED_RAMP_EN is defined).
module tb_dac_sample_sched;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                en_i;
  logic [7:0]          osr_i;
  logic                s_valid_i;
  logic signed [15:0]  s_data_i;
  logic                s_ready_o;
  logic signed [15:0]  dac_o;
  logic                strobe_o;
  logic                underflow_o;
  logic                clr_i;
  logic [1:0]          state_o;

  int checks   = 0;
  int failures = 0;

  dac_sample_sched #(.BW(16), .OSR_W(8), .DEPTH(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .osr_i       (osr_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .dac_o       (dac_o),
    .strobe_o    (strobe_o),
    .underflow_o (underflow_o),
    .clr_i       (clr_i),
    .state_o     (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one edge; a sample offered while ready is taken on that edge, so drop valid afterwards.
  task automatic stepClock();
    logic acc;
    acc = s_valid_i && s_ready_o;
    @(posedge clk_i);
    #1;
    if (acc) s_valid_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic signed [15:0] d);
    s_data_i  = d;
    s_valid_i = 1'b1;
    stepClock();
  endtask

  task automatic applyReset();
    rst_i     = 1'b0;
    en_i      = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    clr_i     = 1'b0;
    repeat (3) stepClock();
  endtask

  task automatic waitStrobe(input string tag);
    int n;
    n = 0;
    do begin
      stepClock();
      n++;
    end while (!strobe_o && n < 40);
    checkOutput(tag, strobe_o, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_a[3];
    exp_a = '{100, -200, 300};
    osr_i = 8'd3;

    // Reset and prime/run with osr 3
    applyReset();
    checkOutput("rst_dac", dac_o, 0);
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_ready", s_ready_o, 0);
    checkOutput("rst_uflow", underflow_o, 0);
    checkOutput("rst_strobe", strobe_o, 0);
    rst_i = 1'b1;
    #1;
    checkOutput("rel_ready", s_ready_o, 1);

    en_i = 1'b1;
    applyStimulus(16'sd100);
    checkOutput("a_prime1", state_o, 1);
    applyStimulus(-16'sd200);
    checkOutput("a_prime2", state_o, 1);
    applyStimulus(16'sd300);
    checkOutput("a_run", state_o, 2);
    for (int i = 0; i < 3; i++) begin
      for (int k = 1; k <= 4; k++) begin
        stepClock();
        checkOutput("a_strobe", strobe_o, (k == 4) ? 1 : 0);
      end
      checkOutput("a_dac", dac_o, exp_a[i]);
      checkOutput("a_uflow0", underflow_o, 0);
    end
    for (int k = 1; k <= 4; k++) stepClock();
    checkOutput("a_uf_strobe", strobe_o, 1);
    checkOutput("a_uf_dac", dac_o, 300);
    checkOutput("a_uf_flag", underflow_o, 1);

    applyStimulus(16'sd1);
    applyStimulus(16'sd2);
    en_i = 1'b0;
    stepClock();
`ifndef DAC_SCHED_RAMP_EN
    checkOutput("stop_state", state_o, 0);
    checkOutput("stop_dac", dac_o, 0);
    checkOutput("stop_strobe", strobe_o, 0);
    en_i = 1'b1;
    stepClock();
    checkOutput("flush_prime", state_o, 1);
    stepClock();
    checkOutput("flush_stay", state_o, 1);
`else
    checkOutput("stop_mute", state_o, 3);
`endif

    // Full FIFO in IDLE, then drain with osr 0
    applyReset();
    rst_i = 1'b1;
    osr_i = 8'd0;
    applyStimulus(16'sd10);
    applyStimulus(16'sd20);
    applyStimulus(16'sd30);
    applyStimulus(16'sd40);
    checkOutput("full_ready", s_ready_o, 0);
    s_data_i  = 16'sd50;
    s_valid_i = 1'b1;
    stepClock();
    stepClock();
    checkOutput("full_hold", s_ready_o, 0);
    checkOutput("full_idle", state_o, 0);
    en_i = 1'b1;
    stepClock();
    checkOutput("b_prime", state_o, 1);
    stepClock();
    checkOutput("b_run", state_o, 2);
    for (int i = 0; i < 5; i++) begin
      stepClock();
      checkOutput("b_strobe", strobe_o, 1);
      checkOutput("b_dac", dac_o, 10 * (i + 1));
    end
    checkOutput("b_uflow0", underflow_o, 0);
    stepClock();
    checkOutput("b_uf_dac", dac_o, 50);
    checkOutput("b_uf_flag", underflow_o, 1);

    // Underflow and clear with osr 2
    applyReset();
    rst_i = 1'b1;
    osr_i = 8'd2;
    en_i  = 1'b1;
    applyStimulus(16'sd7);
    applyStimulus(16'sd9);
    stepClock();
    checkOutput("c_run", state_o, 2);
    waitStrobe("c_tick1");
    checkOutput("c_dac1", dac_o, 7);
    checkOutput("c_uf1", underflow_o, 0);
    waitStrobe("c_tick2");
    checkOutput("c_dac2", dac_o, 9);
    checkOutput("c_uf2", underflow_o, 0);
    waitStrobe("c_tick3");
    checkOutput("c_dac3", dac_o, 9);
    checkOutput("c_uf3", underflow_o, 1);
    clr_i = 1'b1;
    stepClock();
    clr_i = 1'b0;
    checkOutput("c_clr", underflow_o, 0);
    stepClock();
    clr_i = 1'b1;
    stepClock();
    clr_i = 1'b0;
    checkOutput("c_coinc_strobe", strobe_o, 1);
    checkOutput("c_coinc_uf", underflow_o, 1);
    stepClock();
    checkOutput("c_sticky", underflow_o, 1);

`ifdef DAC_SCHED_RAMP_EN
    // Ramp stop from 1024 with osr 0
    begin
      int e;
      int n;
      applyReset();
      rst_i = 1'b1;
      osr_i = 8'd0;
      en_i  = 1'b1;
      applyStimulus(16'sd1024);
      applyStimulus(16'sd1024);
      stepClock();
      checkOutput("e_run", state_o, 2);
      stepClock();
      checkOutput("e_dac", dac_o, 1024);
      en_i = 1'b0;
      stepClock();
      checkOutput("e_mute", state_o, 3);
      checkOutput("e_mute_strobe", strobe_o, 0);
      stepClock();
      checkOutput("e_r1", dac_o, 896);
      stepClock();
      checkOutput("e_r2", dac_o, 784);
      stepClock();
      checkOutput("e_r3", dac_o, 686);
      e = 686;
      n = 0;
      while (e != 0 && n < 100) begin
        e = (e < 8) ? 0 : e - e / 8;
        stepClock();
        n++;
        checkOutput("e_ramp_strobe", strobe_o, 1);
        checkOutput("e_ramp", dac_o, e);
      end
      checkOutput("e_done", n < 100 ? 1 : 0, 1);
      checkOutput("e_idle", state_o, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_sample_sched.md
# dac_sample_sched

Sample scheduler placed ahead of the FIR smoothing filter and delta-sigma modulator. Buffers signed samples from an upstream producer through a valid/ready handshake in a small FIFO. Releases exactly one sample to the DAC chain every `osr_i+1` clock cycles, and handles start-up priming, underflow and an orderly stop.

## Interface
- `BW`, 16, sample width (matches the DAC chain width)
- `OSR_W`, 8, width of the oversampling period register
- `DEPTH`, 4, FIFO depth; power of two, at least 2

- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; synchronous, active-low
- `en_i`  in  1  run enable; level-sensitive
- `osr_i`  in  OSR_W  output period minus one, in clock cycles
- `s_valid_i`  in  1  upstream sample valid
- `s_data_i`  in  BW  upstream sample, signed two's complement
- `s_ready_o`  out  1  FIFO can accept a sample
- `dac_o`  out  BW  signed sample to the filter/DAC input, registered
- `strobe_o`  out  1  one-cycle pulse on each output tick
- `underflow_o`  out  1  sticky underflow flag
- `clr_i`  in  1  clears `underflow_o`
- `state_o`  out  2  current state: IDLE=0, PRIME=1, RUN=2, MUTE=3

## Operation
- **FIFO**
  - A push occurs when `s_valid_i && s_ready_o`.
  - `s_ready_o = (count != DEPTH) && rst_i`.
  - A push while full is never accepted, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave `count` unchanged.
  - Pushes are accepted in every state.
- **Tick counter**
  - Active in RUN and MUTE only; cleared in IDLE and PRIME.
  - A tick occurs when `cnt >= osr_i`. The counter returns to 0 on a tick and increments otherwise.
  - Using `>=` makes a shrinking `osr_i` mid-run safe.
- **IDLE**
  - `dac_o = 0`.
  - `en_i = 1` moves to PRIME.
- **PRIME**
  - When `count >= DEPTH/2`, move to RUN.
  - When `en_i = 0`, return to IDLE.
- **RUN**
  - On each tick, `strobe_o` pulses.
  - If the FIFO is non-empty, pop the head into `dac_o`.
  - If the FIFO is empty, hold `dac_o` and set `underflow_o`. The block stays in RUN.
  - When `en_i = 0`, take the stop action described under Configuration.
- **MUTE** (exists only with `DAC_SCHED_RAMP_EN`)
  - On each tick, `strobe_o` pulses and `dac_o` steps toward 0:
    - if `|dac_o| < 8`, `dac_o <= 0`;
    - otherwise `dac_o <= dac_o - (dac_o >>> 3)`.
  - When the tick that produces 0 occurs, move to IDLE.
  - `en_i` is ignored in MUTE.
- **Flush**: the FIFO is flushed (count to 0) on every entry to IDLE from RUN or MUTE.
- **Underflow flag**
  - `underflow_o` is sticky and is cleared by `clr_i`.
  - If set and clear occur in the same cycle, set wins.
- **Arithmetic**: the ramp uses a signed arithmetic shift at BW bits; no result exceeds `|dac_o|`, so no overflow is possible.

## Timing
- **Reset** (`rst_i = 0` at a clock edge), next cycle:
  - state IDLE, FIFO empty, `cnt = 0`;
  - `dac_o = 0`, `strobe_o = 0`, `underflow_o = 0`;
  - `s_ready_o = 0` while reset is held, then 1.
- Reset asserted mid-operation aborts immediately, with no ramp.
- A sample pushed at edge t is counted at t+1 and is poppable from t+1.
- PRIME→RUN occurs on the edge after `count` reaches `DEPTH/2`.
- The first tick occurs `osr_i+1` cycles after entry to RUN.
- `dac_o` and `strobe_o` update on the same edge; `strobe_o` is high for exactly one cycle.
- With `osr_i = 0`, a tick occurs every cycle.

## Configuration
- **`DAC_SCHED_RAMP_EN` defined**:
  - `en_i` falling in RUN moves the block to MUTE.
  - `dac_o` decays geometrically to 0 on ticks before the block enters IDLE.
- **`DAC_SCHED_RAMP_EN` undefined**:
  - MUTE is unreachable.
  - `en_i` falling in RUN moves the block to IDLE on the next edge, with `dac_o = 0`, `strobe_o = 0` and the FIFO flushed.

## Test plan
- **Reset**: hold `rst_i = 0` for 3 cycles → `dac_o = 0`, `state_o = 0`, `s_ready_o = 0`, `underflow_o = 0`; release → `s_ready_o = 1`.
- **Prime and run**:
  - stimulus: `DEPTH = 4`, `osr_i = 3`, `en_i = 1`; push 100, -200, 300;
  - response: RUN is entered after the 2nd sample is counted; `strobe_o` pulses every 4 cycles; `dac_o` shows 100, -200, 300 in order.
- **Full FIFO**: push 5 samples back-to-back in IDLE → `s_ready_o` is 0 after 4 samples; the 5th is held and later accepted, in order.
- **Underflow**:
  - stimulus: in RUN, supply 2 samples (7, 9), then stop pushing;
  - response: on the 3rd tick `dac_o` stays 9 and `underflow_o = 1`;
  - pulsing `clr_i` clears the flag; `clr_i` coincident with a new underflow leaves it at 1.
- **Stop with ramp** (`DAC_SCHED_RAMP_EN`):
  - stimulus: `dac_o = 1024`, drop `en_i`;
  - response: tick values 896, 784, 686, …, then below 8 → 0, then IDLE.
- **Stop without ramp**: same stimulus → IDLE and `dac_o = 0` on the next edge; FIFO count is 0.
